// File: rtl/spi_cfg_sequencer_if.sv
// Handshake bundle between the config sequencer, its table memory, the host
// write port and the downstream SPI frame serializer.
interface spi_cfg_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic              abort;
  logic              tbl_rd_en;
  logic [ADDR_W-1:0] tbl_addr;
  logic [23:0]       tbl_data;
  logic              host_req;
  logic [23:0]       host_word;
  logic              host_ack;
  logic              spi_start;
  logic [23:0]       spi_word;
  logic              spi_busy;
  logic              spi_done;
  logic              seq_busy;
  logic              seq_done;
  logic              seq_error;
  logic [ADDR_W-1:0] entry_idx;

  modport master (
    input  start, abort, tbl_data, host_req, host_word, spi_busy, spi_done,
    output tbl_rd_en, tbl_addr, host_ack, spi_start, spi_word,
           seq_busy, seq_done, seq_error, entry_idx
  );

  modport slave (
    output start, abort, tbl_data, host_req, host_word, spi_busy, spi_done,
    input  tbl_rd_en, tbl_addr, host_ack, spi_start, spi_word,
           seq_busy, seq_done, seq_error, entry_idx
  );
endinterface

// File: rtl/spi_cfg_sequencer.sv
// Walks a {addr,data} configuration table into the SPI serializer one frame at
// a time, with an inter-frame gap, frame timeout and host-write insertion.
module spi_cfg_sequencer #(
  parameter int NUM_ENTRIES    = 368,
  parameter int ADDR_W         = 9,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  spi_cfg_sequencer_if.master bus
);

  localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, GAP, H_ISSUE, H_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       word_q,  word_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [7:0]        tmo_q,   tmo_d;
  logic [GAP_W-1:0]  gap_q,   gap_d;
  logic              busy_q,  busy_d;
  logic              err_q,   err_d;
  logic              abort_q, abort_d;
  logic              done_q,  done_d;

  logic tbl_rd_en_c;
  logic spi_start_c;
  logic host_ack_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge value of its neighbours, independent of statement order.
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal written below gets a default first; a path that
    // skipped one would otherwise infer a latch.
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    busy_d      = busy_q;
    err_d       = err_q;
    abort_d     = abort_q | (busy_q & bus.abort);
    done_d      = 1'b0;
    tbl_rd_en_c = 1'b0;
    spi_start_c = 1'b0;
    host_ack_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.host_req) begin
          word_d  = bus.host_word;
          state_d = H_ISSUE;
        end else if (bus.start) begin
          err_d   = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          abort_d = 1'b0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        tbl_rd_en_c = 1'b1;
        state_d     = LATCH;
      end

      LATCH: begin
        word_d  = bus.tbl_data;
        state_d = ISSUE;
      end

      // spi_start is decoded straight from the state so the first frame leaves
      // three cycles after an accepted start.
      ISSUE, H_ISSUE: begin
        if (!bus.spi_busy) begin
          spi_start_c = 1'b1;
          tmo_d       = '0;
          state_d     = (state_q == ISSUE) ? WAIT_DONE : H_WAIT;
        end
      end

      WAIT_DONE: begin
        if (bus.spi_done) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          abort_d = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      H_WAIT: begin
        if (bus.spi_done) begin
          host_ack_c = 1'b1;
          gap_d      = GAP_LOAD;
          state_d    = GAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      GAP: begin
        if (gap_q > GAP_W'(1)) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (bus.host_req) begin
          word_d  = bus.host_word;
          state_d = H_ISSUE;
        end else if (!busy_q) begin
          state_d = IDLE;
        end else if (abort_q || bus.abort || idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          abort_d = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.tbl_rd_en = tbl_rd_en_c;
  assign bus.tbl_addr  = idx_q;
  assign bus.spi_start = spi_start_c;
  assign bus.spi_word  = word_q;
  assign bus.host_ack  = host_ack_c;
  assign bus.seq_busy  = busy_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_error = err_q;
  assign bus.entry_idx = idx_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench: directed runs push expected frames/completions; a negedge
// monitor pops and compares as the DUT presents them.
module tb_spi_cfg_sequencer;
  localparam int ADDR_W        = 9;
  localparam int NUM_ENTRIES   = 4;
  localparam int GAP           = 4;
  localparam int TMO           = 255;
  localparam int DONE_LAT      = 41;
  // done cycle, GAP cycles, then FETCH + LATCH before the next ISSUE
  localparam int FRAME_SPACING = DONE_LAT + 1 + GAP + 2;
  localparam logic [23:0] HOST_WORD = 24'hA55A3C;

  typedef struct packed {
    logic              err;
    logic [ADDR_W-1:0] idx;
  } done_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic model_busy = 1'b0;
  logic ext_busy = 1'b0;
  logic model_hang = 1'b0;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [23:0] exp_word[$];
  done_t       exp_done[$];
  int          exp_ack = 0;
  int          start_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          ack_cnt = 0;
  logic        in_flight = 1'b0;
  logic        word_moved = 1'b0;
  logic [23:0] flight_word = '0;

  spi_cfg_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  spi_cfg_sequencer #(
    .NUM_ENTRIES   (NUM_ENTRIES),
    .ADDR_W        (ADDR_W),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.spi_busy = model_busy | ext_busy;

  function automatic logic [23:0] tbl_word(input logic [ADDR_W-1:0] a);
    case (a)
      9'd0:    return 24'h001234;
      9'd1:    return 24'h00A1FF;
      9'd2:    return 24'h7F0055;
      9'd3:    return 24'h123480;
      default: return 24'hDEAD00;
    endcase
  endfunction

  // synchronous-read table memory
  always @(posedge clk) if (bus.tbl_rd_en) bus.tbl_data <= tbl_word(bus.tbl_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input int act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: observed %0d, nothing expected or bound expired (cycle %0d)", name, act, cyc);
  endtask

  // serializer model: busy from the cycle after spi_start, done DONE_LAT cycles later
  initial begin
    bus.spi_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.spi_start && !reset && !model_hang) begin
        @(posedge clk); #1 model_busy = 1'b1;
        repeat (DONE_LAT - 1) @(posedge clk);
        #1 model_busy = 1'b0;
        bus.spi_done = 1'b1;
        @(posedge clk); #1 bus.spi_done = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    done_t d;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_flight = 1'b0;
      end else begin
        if (bus.spi_start) begin
          start_cyc.push_back(cyc);
          if (exp_word.size() == 0) flag_fail("unexpected_frame", int'(bus.spi_word));
          else check("frame_word", bus.spi_word, exp_word.pop_front());
          in_flight   = 1'b1;
          word_moved  = 1'b0;
          flight_word = bus.spi_word;
        end else if (in_flight) begin
          if (bus.spi_word !== flight_word) word_moved = 1'b1;
          if (bus.spi_done) begin
            check("word_stable", word_moved, 0);
            in_flight = 1'b0;
          end
        end
        if (bus.host_ack) begin
          ack_cnt++;
          if (exp_ack == 0) flag_fail("unexpected_host_ack", ack_cnt);
          else exp_ack--;
        end
        if (bus.seq_done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_done.size() == 0) begin
            flag_fail("unexpected_seq_done", done_cnt);
          end else begin
            d = exp_done.pop_front();
            check("done_entry_idx", bus.entry_idx, d.idx);
            check("done_seq_error", bus.seq_error, d.err);
            check("done_busy_low", bus.seq_busy, 0);
          end
        end
      end
    end
  end

  task automatic pulse_start(output int c);
    @(posedge clk); #1 bus.start = 1'b1;
    c = cyc;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (start_cyc.size() < n && k < budget) begin @(posedge clk); k++; end
    if (start_cyc.size() < n) flag_fail("spi_start_wait", start_cyc.size());
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin @(posedge clk); k++; end
    if (done_cnt < target) flag_fail("seq_done_wait", done_cnt);
  endtask

  task automatic push_run();
    for (int i = 0; i < NUM_ENTRIES; i++) exp_word.push_back(tbl_word(ADDR_W'(i)));
    exp_done.push_back('{err: 1'b0, idx: ADDR_W'(NUM_ENTRIES - 1)});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_spi_start"}, bus.spi_start, 0);
    check({tag, "_tbl_rd_en"}, bus.tbl_rd_en, 0);
    check({tag, "_tbl_addr"},  bus.tbl_addr,  0);
    check({tag, "_host_ack"},  bus.host_ack,  0);
    check({tag, "_spi_word"},  bus.spi_word,  0);
    check({tag, "_seq_busy"},  bus.seq_busy,  0);
    check({tag, "_seq_done"},  bus.seq_done,  0);
    check({tag, "_seq_error"}, bus.seq_error, 0);
    check({tag, "_entry_idx"}, bus.entry_idx, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_frames_left"}, exp_word.size(), 0);
    check({tag, "_dones_left"},  exp_done.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d0;
    int a0;
    int k;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.host_req  = 1'b0;
    bus.host_word = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // full 4-entry walk
    start_cyc.delete();
    push_run();
    d0 = done_cnt;
    pulse_start(c);
    wait_done(d0 + 1, 600);
    check("run_frames", start_cyc.size(), 4);
    if (start_cyc.size() >= 4) begin
      check("run_first_latency", start_cyc[0] - c, 3);
      check("run_spacing_01", start_cyc[1] - start_cyc[0], FRAME_SPACING);
      check("run_spacing_23", start_cyc[3] - start_cyc[2], FRAME_SPACING);
    end
    @(negedge clk);
    check("run_entry_idx_hold", bus.entry_idx, 3);
    check("run_busy_after", bus.seq_busy, 0);
    check_drained("run");

    // host write inserted after frame 1
    start_cyc.delete();
    exp_word.push_back(tbl_word(9'd0));
    exp_word.push_back(tbl_word(9'd1));
    exp_word.push_back(HOST_WORD);
    exp_word.push_back(tbl_word(9'd2));
    exp_word.push_back(tbl_word(9'd3));
    exp_done.push_back('{err: 1'b0, idx: ADDR_W'(3)});
    exp_ack = 1;
    a0 = ack_cnt;
    d0 = done_cnt;
    bus.host_word = HOST_WORD;
    pulse_start(c);
    wait_starts(2, 200);
    @(posedge clk); #1 bus.host_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.host_ack && k < 400);
    if (!bus.host_ack) flag_fail("host_ack_wait", k);
    @(posedge clk); #1 bus.host_req = 1'b0;
    wait_done(d0 + 1, 600);
    check("host_frames", start_cyc.size(), 5);
    check("host_ack_count", ack_cnt - a0, 1);
    check_drained("host");

    // abort during frame 1
    start_cyc.delete();
    exp_word.push_back(tbl_word(9'd0));
    exp_word.push_back(tbl_word(9'd1));
    exp_done.push_back('{err: 1'b0, idx: ADDR_W'(1)});
    d0 = done_cnt;
    pulse_start(c);
    wait_starts(2, 200);
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    wait_done(d0 + 1, 200);
    repeat (60) @(posedge clk);
    check("abort_frames", start_cyc.size(), 2);
    @(negedge clk);
    check("abort_busy_low", bus.seq_busy, 0);
    check_drained("abort");

    // serializer hangs: timeout, then a fresh start clears the error
    start_cyc.delete();
    model_hang = 1'b1;
    exp_word.push_back(tbl_word(9'd0));
    exp_done.push_back('{err: 1'b1, idx: ADDR_W'(0)});
    d0 = done_cnt;
    pulse_start(c);
    wait_done(d0 + 1, 600);
    if (start_cyc.size() > 0) check("timeout_cycles", done_cyc - start_cyc[0], TMO + 1);
    @(negedge clk);
    check("timeout_error_sticky", bus.seq_error, 1);
    check("timeout_busy_low", bus.seq_busy, 0);
    model_hang = 1'b0;
    push_run();
    d0 = done_cnt;
    pulse_start(c);
    @(negedge clk);
    check("restart_error_cleared", bus.seq_error, 0);
    check("restart_busy", bus.seq_busy, 1);
    wait_done(d0 + 1, 600);
    check_drained("timeout");

    // serializer busy for 10 cycles at the first ISSUE
    start_cyc.delete();
    ext_busy = 1'b1;
    push_run();
    d0 = done_cnt;
    pulse_start(c);
    do @(negedge clk); while (cyc < c + 3);
    for (int i = 0; i < 10; i++) begin
      check("busy_word_hold", bus.spi_word, tbl_word(9'd0));
      check("busy_no_start", bus.spi_start, 0);
      if (i < 9) @(negedge clk);
    end
    @(posedge clk); #1 ext_busy = 1'b0;
    wait_starts(1, 20);
    if (start_cyc.size() > 0) check("busy_release_latency", start_cyc[0] - c, 13);
    wait_done(d0 + 1, 600);
    check_drained("busy");

    // reset asserted mid-frame 1, then a clean restart from entry 0
    start_cyc.delete();
    exp_word.push_back(tbl_word(9'd0));
    exp_word.push_back(tbl_word(9'd1));
    pulse_start(c);
    wait_starts(2, 200);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_outputs_zero("midreset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (60) @(posedge clk);
    check("midreset_no_frames", start_cyc.size(), 2);
    check_drained("midreset");
    push_run();
    d0 = done_cnt;
    pulse_start(c);
    wait_done(d0 + 1, 600);
    check("postreset_frames", start_cyc.size(), 6);
    if (start_cyc.size() > 2) check("postreset_latency", start_cyc[2] - c, 3);
    check_drained("postreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
Sequences a device configuration table of 24-bit {addr[23:8], data[7:0]} entries into the downstream SPI frame serializer, one frame at a time. It fetches each entry from a synchronous-read table RAM/ROM, launches a frame, waits for completion, and enforces an inter-frame gap. It also arbitrates single host register writes onto the same serializer, inserting them only between table frames. It sits between the boot/config control logic and the SPI serializer.

Parameters:
NUM_ENTRIES, 368, number of table entries walked per sequence (1..2^ADDR_W)
ADDR_W, 9, table address width
GAP_CYCLES, 4, idle clk cycles enforced after every frame completion (0 allowed)
TIMEOUT_CYCLES, 255, max clk cycles from spi_start to spi_done before error (8-bit counter)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin table sequence; ignored unless idle
abort  in  1  pulse: stop after the in-flight frame completes
tbl_rd_en  out  1  table read strobe
tbl_addr  out  ADDR_W  table read address
tbl_data  in  24  table word, valid the cycle after tbl_rd_en
host_req  in  1  host write request, level, held until host_ack
host_word  in  24  host {addr, data}, stable while host_req high
host_ack  out  1  1-cycle pulse: host frame completed
spi_start  out  1  1-cycle pulse launching a frame
spi_word  out  24  frame payload, held stable from spi_start until spi_done
spi_busy  in  1  serializer busy; spi_start issued only when low
spi_done  in  1  1-cycle pulse: serializer finished frame
seq_busy  out  1  high from accepted start until sequence ends
seq_done  out  1  1-cycle pulse: sequence completed or aborted
seq_error  out  1  sticky timeout flag, cleared by next accepted start or reset
entry_idx  out  ADDR_W  index of current/last issued table entry

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, host-pending flag cleared. Reset mid-frame abandons frame immediately; no done/ack generated.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, GAP, H_ISSUE, H_WAIT.
- IDLE: host_req high -> H_ISSUE (host has priority only while idle or at gap end). Else start -> clear seq_error, entry_idx=0, seq_busy=1, FETCH.
- FETCH: tbl_rd_en=1, tbl_addr=entry_idx, -> LATCH (1 cycle).
- LATCH: capture tbl_data into spi_word, -> ISSUE.
- ISSUE: wait for spi_busy=0, then spi_start pulse, timeout counter cleared, -> WAIT_DONE. Latency start->first spi_start = 3 cycles when serializer idle.
- WAIT_DONE: spi_done -> GAP with gap counter loaded. Timeout counter reaching TIMEOUT_CYCLES without spi_done -> seq_error=1, seq_done pulse, seq_busy=0, IDLE.
- GAP: count GAP_CYCLES (GAP_CYCLES=0: one transit cycle). At expiry, priority: host_req -> H_ISSUE (host frame inserted, table resumes after); abort latched or last entry (entry_idx==NUM_ENTRIES-1) -> seq_done pulse, seq_busy=0, IDLE; else entry_idx+1, FETCH.
- H_ISSUE: spi_word=host_word, spi_start when spi_busy=0, -> H_WAIT. H_WAIT: spi_done -> host_ack pulse, then GAP (if seq_busy) or IDLE after gap. Timeout in H_WAIT sets seq_error, no host_ack, returns as above.
- abort: latched any time seq_busy; never truncates an in-flight frame; honoured at next GAP expiry; ignored when idle. start while seq_busy ignored.
- Host request arriving with start in same IDLE cycle: host served first, start dropped (start is pulse-only).
- spi_done outside WAIT_DONE/H_WAIT ignored.
- entry_idx never wraps; holds last value after sequence.

Test Plan:
- NUM_ENTRIES=4, GAP_CYCLES=4, serializer model done 41 cycles after start: start -> 4 frames, spi_word = table[0..3], spi_start 3 cycles after start, consecutive frames spaced done+gap, seq_done once, entry_idx=3.
- host_req with host_word=24'hA5_5A_3C during frame 1 -> host frame issued after frame 1 gap, host_ack once, table resumes at entry 2, total 5 frames.
- abort pulse mid-frame 1 of 4 -> frame 1 completes, no frame 2, seq_done pulse, seq_busy=0.
- Serializer never asserts spi_done -> seq_error=1 after 255 cycles, seq_done pulse; next start clears seq_error.
- spi_busy held high 10 cycles at ISSUE -> spi_start delayed until busy low, spi_word stable throughout.
- reset asserted in WAIT_DONE -> all outputs 0 immediately; start afterward restarts at entry 0.
